// File: rtl/mul_div_unit.sv
// ---------------------------------------------------------------------------
// mul_div_unit
//
// Multi-cycle HI/LO unit for the EX stage. It owns the architectural HI and LO
// registers, runs mult/multu (shift-add) and div/divu (radix-2 restoring
// division) over 32 iterations, and requests a pipeline stall through busy
// while an operation is in flight. mthi/mtlo write HI/LO directly in one cycle.
//
// Ports
//   clk       in   core clock
//   reset     in   asynchronous, active-high reset
//   en        in   EX-stage instruction valid, qualifies every strobe
//   flush     in   EX flush; aborts any operation, suppresses all writes
//   is_mult   in   signed multiply strobe        (priority highest)
//   is_multu  in   unsigned multiply strobe
//   is_div    in   signed divide strobe
//   is_divu   in   unsigned divide strobe        (priority lowest)
//   hi_wen    in   mthi strobe
//   lo_wen    in   mtlo strobe
//   rs_data   in   dividend / multiplicand / mthi-mtlo source
//   rt_data   in   divisor / multiplier
//   busy      out  stall request (combinational)
//   hi        out  architectural HI (registered)
//   lo        out  architectural LO (registered)
//
// Configuration
//   FAST_MULT_EN  when defined, mult/multu complete in the start cycle with a
//                 single-cycle 64-bit multiply and never raise busy. Division
//                 stays iterative. Undefined (default): 32-iteration multiply.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | waiting for an op strobe; mthi/mtlo accepted here
// MUL     | shift-add multiply, one multiplier bit per cycle
// DIV     | restoring divide, one quotient bit per cycle
// ---------------------------------------------------------------------------
module mul_div_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        flush,
    input  logic        is_mult,
    input  logic        is_multu,
    input  logic        is_div,
    input  logic        is_divu,
    input  logic        hi_wen,
    input  logic        lo_wen,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;

    logic [1:0]  state;
    logic [4:0]  cnt;
    // acc[63:32] = partial product high / remainder,
    // acc[31:0]  = multiplier shifting out / dividend out, quotient in.
    logic [63:0] acc;
    logic [31:0] opb;      // multiplicand or divisor magnitude
    logic        qsign;    // product / quotient sign
    logic        rsign;    // remainder sign
    logic        div0;
    logic [31:0] rs_lat;

    logic        any_op;
    logic        op_mul;
    logic        op_signed;
    logic        start;
    logic        start_iter;
    logic        last;
    logic [31:0] mag_rs;
    logic [31:0] mag_rt;

    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [32:0] div_shift;
    logic        div_ge;
    logic [31:0] div_diff;
    logic [63:0] div_next;
    logic [63:0] acc_next;
    logic [63:0] prod_fix;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;

    logic        hi_wr;
    logic        lo_wr;
    logic [31:0] hi_d;
    logic [31:0] lo_d;

    // Decode guarantees one-hot strobes; priority only matters for robustness.
    assign any_op    = is_mult | is_multu | is_div | is_divu;
    assign op_mul    = is_mult | is_multu;
    assign op_signed = is_mult | (~is_multu & is_div);
    assign start     = en & ~flush & (state == ST_IDLE) & any_op;
    assign last      = (cnt == 5'd31);

    // Unsigned negation: abs(0x8000_0000) stays 0x8000_0000.
    assign mag_rs = (op_signed & rs_data[31]) ? (32'd0 - rs_data) : rs_data;
    assign mag_rt = (op_signed & rt_data[31]) ? (32'd0 - rt_data) : rt_data;

`ifdef FAST_MULT_EN
    logic        start_fast;
    logic [63:0] fast_prod;

    assign start_fast = start & op_mul;
    assign start_iter = start & ~op_mul;
    assign fast_prod  = {{32{op_signed & rs_data[31]}}, rs_data} *
                        {{32{op_signed & rt_data[31]}}, rt_data};
`else
    assign start_iter = start;
`endif

    assign busy = start_iter | ((state != ST_IDLE) & ~last & ~flush);

    // Shift-add step: add multiplicand to the high half when the current
    // multiplier bit is set, then shift the whole accumulator right by one.
    assign mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opb} : 33'd0);
    assign mul_next = {mul_sum, acc[31:1]};

    // Restoring step: shift the next dividend bit into the remainder; the
    // subtraction result fits 32 bits whenever it is taken.
    assign div_shift = {acc[63:32], acc[31]};
    assign div_ge    = (div_shift >= {1'b0, opb});
    assign div_diff  = div_shift[31:0] - opb;
    assign div_next  = {(div_ge ? div_diff : div_shift[31:0]), acc[30:0], div_ge};

    assign acc_next = (state == ST_MUL) ? mul_next : div_next;

    assign prod_fix = qsign ? (64'd0 - mul_next) : mul_next;
    assign quo_fix  = div0 ? 32'hFFFF_FFFF
                           : (qsign ? (32'd0 - div_next[31:0]) : div_next[31:0]);
    assign rem_fix  = div0 ? rs_lat
                           : (rsign ? (32'd0 - div_next[63:32]) : div_next[63:32]);

    always_comb begin
        hi_wr = 1'b0;
        lo_wr = 1'b0;
        hi_d  = rs_data;
        lo_d  = rs_data;
        if (state == ST_IDLE) begin
            if (en & ~flush) begin
                hi_wr = hi_wen;
                lo_wr = lo_wen;
            end
`ifdef FAST_MULT_EN
            if (start_fast) begin
                hi_wr = 1'b1;
                lo_wr = 1'b1;
                hi_d  = fast_prod[63:32];
                lo_d  = fast_prod[31:0];
            end
`endif
        end else if (last & ~flush) begin
            hi_wr = 1'b1;
            lo_wr = 1'b1;
            if (state == ST_MUL) begin
                hi_d = prod_fix[63:32];
                lo_d = prod_fix[31:0];
            end else begin
                hi_d = rem_fix;
                lo_d = quo_fix;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= ST_IDLE;
            cnt    <= 5'd0;
            acc    <= 64'd0;
            opb    <= 32'd0;
            qsign  <= 1'b0;
            rsign  <= 1'b0;
            div0   <= 1'b0;
            rs_lat <= 32'd0;
            hi     <= 32'd0;
            lo     <= 32'd0;
        end else begin
            if (hi_wr)
                hi <= hi_d;
            if (lo_wr)
                lo <= lo_d;

            if (flush) begin
                state <= ST_IDLE;
                cnt   <= 5'd0;
            end else if (state == ST_IDLE) begin
                if (start_iter) begin
                    state  <= op_mul ? ST_MUL : ST_DIV;
                    cnt    <= 5'd0;
                    acc    <= {32'd0, (op_mul ? mag_rt : mag_rs)};
                    opb    <= op_mul ? mag_rs : mag_rt;
                    qsign  <= op_signed & (rs_data[31] ^ rt_data[31]);
                    rsign  <= op_signed & rs_data[31];
                    div0   <= ~op_mul & (rt_data == 32'd0);
                    rs_lat <= rs_data;
                end
            end else begin
                acc <= acc_next;
                cnt <= cnt + 5'd1;
                if (last)
                    state <= ST_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic        flush;
    logic        is_mult;
    logic        is_multu;
    logic        is_div;
    logic        is_divu;
    logic        hi_wen;
    logic        lo_wen;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int vectors    = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t sb_q[$];

    mul_div_unit dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .flush    (flush),
        .is_mult  (is_mult),
        .is_multu (is_multu),
        .is_div   (is_div),
        .is_divu  (is_divu),
        .hi_wen   (hi_wen),
        .lo_wen   (lo_wen),
        .rs_data  (rs_data),
        .rt_data  (rt_data),
        .busy     (busy),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge (input drive point).
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_strobes();
        is_mult  = 1'b0;
        is_multu = 1'b0;
        is_div   = 1'b0;
        is_divu  = 1'b0;
        hi_wen   = 1'b0;
        lo_wen   = 1'b0;
    endtask

    task automatic drive_op(input int op, input logic [31:0] a, input logic [31:0] b);
        clear_strobes();
        en      = 1'b1;
        rs_data = a;
        rt_data = b;
        case (op)
            0: is_mult  = 1'b1;
            1: is_multu = 1'b1;
            2: is_div   = 1'b1;
            default: is_divu = 1'b1;
        endcase
    endtask

    // Called at the drive point of the start cycle. Holds the instruction in
    // EX while busy is high, then compares hi/lo in the cycle after completion.
    task automatic run_op(input string tag, input int op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
        int   n;
        bit   fast;
        exp_t e;
        sb_q.push_back('{hi: eh, lo: el});
        fast = 1'b0;
`ifdef FAST_MULT_EN
        fast = (op < 2);
`endif
        drive_op(op, a, b);
        #2;
        check({tag, "_busy_c0"}, {63'd0, busy}, {63'd0, !fast});
        n = 0;
        if (!fast) begin
            while (busy === 1'b1 && n < 100) begin
                next_cycle();
                #2;
                n++;
            end
            check({tag, "_busy_low_cycle"}, 64'(n), 64'd32);
        end
        next_cycle();
        clear_strobes();
        en = 1'b0;
        #2;
        e = sb_q.pop_front();
        check({tag, "_hi"}, {32'd0, hi}, {32'd0, e.hi});
        check({tag, "_lo"}, {32'd0, lo}, {32'd0, e.lo});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b1;
        en      = 1'b0;
        flush   = 1'b0;
        rs_data = 32'd0;
        rt_data = 32'd0;
        clear_strobes();
        repeat (2) next_cycle();
        reset = 1'b0;
        #2;
        check("reset_hi",   {32'd0, hi},   64'd0);
        check("reset_lo",   {32'd0, lo},   64'd0);
        check("reset_busy", {63'd0, busy}, 64'd0);
        next_cycle();

        run_op("divu_100_7",  3, 32'd100,        32'd7,          32'd2,          32'd14);
        run_op("div_m7_2",    2, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  32'hFFFF_FFFD);
        run_op("div_ovf",     2, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000);
        run_op("divu_by0",    3, 32'd5,          32'd0,          32'd5,          32'hFFFF_FFFF);
        run_op("div_by0",     2, 32'hFFFF_FFF0,  32'd0,          32'hFFFF_FFF0,  32'hFFFF_FFFF);
        run_op("mult_m1_2",   0, 32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFF,  32'hFFFF_FFFE);
        run_op("multu_m1_2",  1, 32'hFFFF_FFFF,  32'd2,          32'd1,          32'hFFFF_FFFE);
        run_op("mult_min_min",0, 32'h8000_0000,  32'h8000_0000,  32'h4000_0000,  32'd0);
        run_op("multu_big",   1, 32'h1234_5678,  32'h9ABC_DEF0,  32'h0B00_EA4E,  32'h242D_2080);

        // Flush mid-divide: hi/lo keep their mthi/mtlo values.
        clear_strobes();
        en      = 1'b1;
        hi_wen  = 1'b1;
        lo_wen  = 1'b1;
        rs_data = 32'hA5A5_A5A5;
        next_cycle();
        clear_strobes();
        drive_op(3, 32'd100, 32'd7);
        repeat (10) next_cycle();
        flush = 1'b1;
        #2;
        check("flush_busy_c10", {63'd0, busy}, 64'd0);
        next_cycle();
        flush = 1'b0;
        #2;
        check("flush_hi_kept", {32'd0, hi}, {32'd0, 32'hA5A5_A5A5});
        check("flush_lo_kept", {32'd0, lo}, {32'd0, 32'hA5A5_A5A5});
        run_op("divu_9_3_after_flush", 3, 32'd9, 32'd3, 32'd0, 32'd3);

        // mthi / mtlo then reset mid-divide.
        clear_strobes();
        en      = 1'b1;
        hi_wen  = 1'b1;
        rs_data = 32'h1234_5678;
        #2;
        check("mthi_busy", {63'd0, busy}, 64'd0);
        next_cycle();
        clear_strobes();
        lo_wen  = 1'b1;
        rs_data = 32'h9ABC_DEF0;
        #2;
        check("mthi_hi", {32'd0, hi}, {32'd0, 32'h1234_5678});
        check("mtlo_busy", {63'd0, busy}, 64'd0);
        next_cycle();
        clear_strobes();
        en = 1'b0;
        #2;
        check("mtlo_lo", {32'd0, lo}, {32'd0, 32'h9ABC_DEF0});
        check("mtlo_hi_kept", {32'd0, hi}, {32'd0, 32'h1234_5678});
        next_cycle();
        drive_op(2, 32'd100, 32'd7);
        repeat (5) next_cycle();
        reset = 1'b1;
        en    = 1'b0;
        clear_strobes();
        #2;
        check("rst_mid_hi",   {32'd0, hi},   64'd0);
        check("rst_mid_lo",   {32'd0, lo},   64'd0);
        check("rst_mid_busy", {63'd0, busy}, 64'd0);
        next_cycle();
        reset = 1'b0;
        next_cycle();
        run_op("div_after_reset", 2, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFF2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
